axi_drain_ctrl: RTL

//  In-line AXI4 controller placed in front of a multi-cut AXI path. Tracks outstanding read/write

---
 rtl/axi_drain_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_drain_ctrl.sv
// axi_drain_ctrl: in-line AXI4 drain/isolation controller.
//
// Sits in front of a multi-cut AXI path. It counts outstanding write and read transactions,
// blocks new AW/AR/W traffic when asked to, lets in-flight bursts finish, and then reports
// that everything downstream is idle. This makes it safe to reset, clock-gate or reconfigure
// the downstream logic.
//
// Ports:
//   clk_i       clock, all state on the rising edge
//   rst_ni      asynchronous active-low reset
//   slv_req_i   request from the upstream master
//   slv_resp_o  response to the upstream master
//   mst_req_o   request toward the downstream cut chain
//   mst_resp_i  response from the downstream cut chain
//   isolate_i   level request: 1 = drain and isolate, 0 = resume
//   isolated_o  1 while nothing is outstanding and new traffic is blocked
//   timeout_o   sticky drain-timeout flag
//
// Build option: define AXI_DRAIN_TIMEOUT_EN to add the drain timeout counter. Without it,
// timeout_o is tied to 0 and TimeoutCycles has no effect.

package axi_drain_pkg;
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } ax_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    w_ready;
      b_chan_t b;
      logic    b_valid;
      logic    ar_ready;
      r_chan_t r;
      logic    r_valid;
   } axi_resp_t;
endpackage

module axi_drain_ctrl #(
   parameter int unsigned MaxTxns       = 8,
   parameter int unsigned TimeoutCycles = 1024,
   parameter type         req_t         = axi_drain_pkg::axi_req_t,
   parameter type         resp_t        = axi_drain_pkg::axi_resp_t
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  req_t  slv_req_i,
   output resp_t slv_resp_o,
   output req_t  mst_req_o,
   input  resp_t mst_resp_i,
   input  logic  isolate_i,
   output logic  isolated_o,
   output logic  timeout_o
);

   localparam int unsigned CntW = $clog2(MaxTxns + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);
   // w_pend carries one extra sign bit so a W burst that leads its AW (legal in NORMAL) can
   // push the count below zero without wrapping into the "full" range.
   localparam logic signed [CntW:0] MaxPend  = (CntW + 1)'(MaxTxns);
   localparam logic signed [CntW:0] PendZero = '0;

   typedef enum logic [1:0] {StNormal, StDrain, StIsolated} state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        wr_cnt_q, wr_cnt_d;
   logic [CntW-1:0]        rd_cnt_q, rd_cnt_d;
   logic signed [CntW:0]   w_pend_q, w_pend_d;
   logic                   aw_hold_q, aw_hold_d;
   logic                   ar_hold_q, ar_hold_d;

   logic aw_pass, ar_pass, w_pass;
   logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
   logic idle;

   // Output process: channel gating and status.
   always_comb begin
      aw_pass = ((state_q == StNormal) && (wr_cnt_q < MaxCnt) && (w_pend_q < MaxPend))
                || aw_hold_q;
      ar_pass = ((state_q == StNormal) && (rd_cnt_q < MaxCnt)) || ar_hold_q;
      w_pass  = (state_q == StNormal) || (w_pend_q > PendZero);

      mst_req_o          = slv_req_i;
      mst_req_o.aw_valid = slv_req_i.aw_valid & aw_pass;
      mst_req_o.ar_valid = slv_req_i.ar_valid & ar_pass;
      mst_req_o.w_valid  = slv_req_i.w_valid & w_pass;

      slv_resp_o          = mst_resp_i;
      slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_pass;
      slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_pass;
      slv_resp_o.w_ready  = mst_resp_i.w_ready & w_pass;

      isolated_o = (state_q == StIsolated);
   end

   assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
   assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
   assign w_last_hs = mst_req_o.w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
   assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
   assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

   assign idle = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (w_pend_q == PendZero)
                 && !aw_hold_q && !ar_hold_q;

   // Counters and valid-stability holds. Gating keeps the counts within MaxTxns.
   always_comb begin
      wr_cnt_d = wr_cnt_q + CntW'(aw_hs) - CntW'(b_hs);
      rd_cnt_d = rd_cnt_q + CntW'(ar_hs) - CntW'(r_last_hs);
      w_pend_d = w_pend_q + (CntW + 1)'(aw_hs) - (CntW + 1)'(w_last_hs);

      // Once AW/AR is presented downstream it must stay up until accepted.
      aw_hold_d = aw_hold_q;
      if (aw_hs) begin
         aw_hold_d = 1'b0;
      end else if (mst_req_o.aw_valid) begin
         aw_hold_d = 1'b1;
      end
      ar_hold_d = ar_hold_q;
      if (ar_hs) begin
         ar_hold_d = 1'b0;
      end else if (mst_req_o.ar_valid) begin
         ar_hold_d = 1'b1;
      end
   end

   // Next-state process.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StNormal:   if (isolate_i) state_d = StDrain;
         StDrain: begin
            if (!isolate_i) begin
               state_d = StNormal;
            end else if (idle) begin
               state_d = StIsolated;
            end
         end
         StIsolated: if (!isolate_i) state_d = StNormal;
         default:    state_d = StNormal;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StNormal;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         w_pend_q  <= '0;
         aw_hold_q <= 1'b0;
         ar_hold_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         w_pend_q  <= w_pend_d;
         aw_hold_q <= aw_hold_d;
         ar_hold_q <= ar_hold_d;
      end
   end

`ifdef AXI_DRAIN_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
   localparam logic [TmoW-1:0] TmoMax  = TmoW'(TimeoutCycles);

   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            timeout_q, timeout_d;

   // Counts cycles spent in DRAIN; zero whenever outside DRAIN so each entry starts fresh.
   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == StDrain) begin
         tmo_cnt_d = (tmo_cnt_q == TmoMax) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
      end
      timeout_d = timeout_q;
      if (!isolate_i) begin
         timeout_d = 1'b0;
      end else if ((state_q == StDrain) && (tmo_cnt_q == TmoLast)) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TimeoutCycles;
   assign timeout_o          = 1'b0;
`endif

endmodule
